// File: rtl/sdram_frame_sched.sv
// Frame-level scheduler for the 2-port SDRAM frame buffer: vsync sync/edge detect, load strobes,
// read gating and frame/drop counters. Define FRAME_SCHED_PINGPONG_EN to enable ping-pong bank tracking.
module sdram_frame_sched #(
   parameter int LOAD_CYCLES = 4,
   parameter int SKIP_FRAMES = 2,
   parameter int VS_POL      = 1,
   parameter int CNT_W       = 8
) (
   input  logic             REF_CLK,
   input  logic             RESET,
   input  logic             Sdram_Init_Done,
   input  logic             CAM_VS,
   input  logic             DISP_VS,
   output logic             WR_LOAD,
   output logic             RD_LOAD,
   output logic             Sdram_Read_Valid,
   output logic             Sdram_PingPong_EN,
   output logic             WR_BANK,
   output logic             RD_BANK,
   output logic [CNT_W-1:0] FRAME_CNT,
   output logic [CNT_W-1:0] DROP_CNT
);

   typedef enum logic [1:0] {ST_INIT, ST_SKIP, ST_FILL, ST_RUN} state_t;

   localparam logic       VS_ACT    = (VS_POL != 0);
   localparam logic [3:0] LOAD_INIT = 4'(LOAD_CYCLES);
   localparam logic [3:0] SKIP_LAST = 4'(SKIP_FRAMES);

   logic [1:0]       cam_sync, disp_sync;
   logic             cam_lvl_d, disp_lvl_d;
   logic             cam_lvl, disp_lvl, cam_start, disp_start;
   state_t           state, state_nxt;
   logic [3:0]       skip_cnt, skip_nxt;
   logic [3:0]       wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt;
   logic             unread, unread_nxt;
   logic [CNT_W-1:0] frame_nxt, drop_nxt;
   logic             wr_load_nxt, rd_load_nxt, valid_nxt;

   assign cam_lvl    = (cam_sync[1] == VS_ACT);
   assign disp_lvl   = (disp_sync[1] == VS_ACT);
   assign cam_start  = cam_lvl & ~cam_lvl_d;
   assign disp_start = disp_lvl & ~disp_lvl_d;

   always_ff @(posedge REF_CLK) begin
      if (RESET) begin
         cam_sync   <= {2{~VS_ACT}};
         disp_sync  <= {2{~VS_ACT}};
         cam_lvl_d  <= 1'b0;
         disp_lvl_d <= 1'b0;
      end else begin
         cam_sync   <= {cam_sync[0], CAM_VS};
         disp_sync  <= {disp_sync[0], DISP_VS};
         cam_lvl_d  <= cam_lvl;
         disp_lvl_d <= disp_lvl;
      end
   end

   always_comb begin
      state_nxt  = state;
      skip_nxt   = skip_cnt;
      wr_cnt_nxt = (wr_cnt != 4'd0) ? wr_cnt - 4'd1 : wr_cnt;
      rd_cnt_nxt = (rd_cnt != 4'd0) ? rd_cnt - 4'd1 : rd_cnt;
      unread_nxt = unread;
      frame_nxt  = FRAME_CNT;
      drop_nxt   = DROP_CNT;
      unique case (state)
         ST_INIT: begin
            skip_nxt   = 4'd0;
            wr_cnt_nxt = 4'd0;
            rd_cnt_nxt = 4'd0;
            unread_nxt = 1'b0;
            if (Sdram_Init_Done) state_nxt = ST_SKIP;
         end
         ST_SKIP: begin
            if (cam_start) begin
               if (skip_cnt == SKIP_LAST) begin
                  state_nxt  = ST_FILL;
                  wr_cnt_nxt = LOAD_INIT;
               end else begin
                  skip_nxt = skip_cnt + 4'd1;
               end
            end
         end
         ST_FILL: begin
            if (cam_start) begin
               state_nxt  = ST_RUN;
               wr_cnt_nxt = LOAD_INIT;
            end
         end
         ST_RUN: begin
            if (cam_start) begin
               wr_cnt_nxt = LOAD_INIT;
               unread_nxt = 1'b1;
               if (!(&FRAME_CNT)) frame_nxt = FRAME_CNT + CNT_W'(1);
               if (unread && !disp_start && !(&DROP_CNT)) drop_nxt = DROP_CNT + CNT_W'(1);
            end
            if (disp_start) begin
               rd_cnt_nxt = LOAD_INIT;
               if (!cam_start) unread_nxt = 1'b0;
            end
         end
      endcase
      // Losing SDRAM init overrides everything else; counters are kept.
      if (!Sdram_Init_Done) state_nxt = ST_INIT;
      wr_load_nxt = (state_nxt == ST_INIT) || (state_nxt == ST_SKIP) || (wr_cnt_nxt != 4'd0);
      rd_load_nxt = (state_nxt != ST_RUN) || (rd_cnt_nxt != 4'd0);
      valid_nxt   = (state_nxt == ST_RUN);
   end

   always_ff @(posedge REF_CLK) begin
      if (RESET) begin
         state            <= ST_INIT;
         skip_cnt         <= 4'd0;
         wr_cnt           <= 4'd0;
         rd_cnt           <= 4'd0;
         unread           <= 1'b0;
         FRAME_CNT        <= '0;
         DROP_CNT         <= '0;
         WR_LOAD          <= 1'b1;
         RD_LOAD          <= 1'b1;
         Sdram_Read_Valid <= 1'b0;
      end else begin
         state            <= state_nxt;
         skip_cnt         <= skip_nxt;
         wr_cnt           <= wr_cnt_nxt;
         rd_cnt           <= rd_cnt_nxt;
         unread           <= unread_nxt;
         FRAME_CNT        <= frame_nxt;
         DROP_CNT         <= drop_nxt;
         WR_LOAD          <= wr_load_nxt;
         RD_LOAD          <= rd_load_nxt;
         Sdram_Read_Valid <= valid_nxt;
      end
   end

`ifdef FRAME_SCHED_PINGPONG_EN
   logic wr_bank_q, rd_bank_q;

   // The reader takes the half opposite to the one being written before this cycle's toggle.
   always_ff @(posedge REF_CLK) begin
      if (RESET) begin
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else if (state == ST_RUN) begin
         if (cam_start)  wr_bank_q <= ~wr_bank_q;
         if (disp_start) rd_bank_q <= ~wr_bank_q;
      end
   end

   assign Sdram_PingPong_EN = 1'b1;
   assign WR_BANK           = wr_bank_q;
   assign RD_BANK           = rd_bank_q;
`else
   assign Sdram_PingPong_EN = 1'b0;
   assign WR_BANK           = 1'b0;
   assign RD_BANK           = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Directed self-checking bench for sdram_frame_sched; a second CNT_W=2 instance shares the
// stimulus to show counter saturation.
module tb_sdram_frame_sched;

`ifdef FRAME_SCHED_PINGPONG_EN
   localparam logic PP = 1'b1;
`else
   localparam logic PP = 1'b0;
`endif

   logic       REF_CLK = 1'b0;
   logic       RESET, Sdram_Init_Done, CAM_VS, DISP_VS;
   logic       WR_LOAD, RD_LOAD, Sdram_Read_Valid, Sdram_PingPong_EN, WR_BANK, RD_BANK;
   logic [7:0] FRAME_CNT, DROP_CNT;
   logic       wr2, rd2, v2, pp2, wb2, rb2;
   logic [1:0] f2, d2;

   int   errors = 0;
   int   checks = 0;
   logic wb_model = 1'b0;
   logic rb_model = 1'b0;
   logic exp_wb, exp_rb;

   always #5 REF_CLK = ~REF_CLK;

   sdram_frame_sched dut (
      .REF_CLK(REF_CLK), .RESET(RESET), .Sdram_Init_Done(Sdram_Init_Done),
      .CAM_VS(CAM_VS), .DISP_VS(DISP_VS), .WR_LOAD(WR_LOAD), .RD_LOAD(RD_LOAD),
      .Sdram_Read_Valid(Sdram_Read_Valid), .Sdram_PingPong_EN(Sdram_PingPong_EN),
      .WR_BANK(WR_BANK), .RD_BANK(RD_BANK), .FRAME_CNT(FRAME_CNT), .DROP_CNT(DROP_CNT)
   );

   sdram_frame_sched #(.CNT_W(2)) dut2 (
      .REF_CLK(REF_CLK), .RESET(RESET), .Sdram_Init_Done(Sdram_Init_Done),
      .CAM_VS(CAM_VS), .DISP_VS(DISP_VS), .WR_LOAD(wr2), .RD_LOAD(rd2),
      .Sdram_Read_Valid(v2), .Sdram_PingPong_EN(pp2),
      .WR_BANK(wb2), .RD_BANK(rb2), .FRAME_CNT(f2), .DROP_CNT(d2)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge REF_CLK);
         #1;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; Sdram_Init_Done = 1'b0; CAM_VS = 1'b0; DISP_VS = 1'b0;
      tick(3);
      RESET = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         checks++;
         if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL init_hold cycle %0d: got wr/rd/valid=%b expected 110", i, {WR_LOAD, RD_LOAD, Sdram_Read_Valid});
         end
      end
      checks++;
      if ({FRAME_CNT, DROP_CNT} !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_counters: got frame=%0d drop=%0d expected 0 0", FRAME_CNT, DROP_CNT);
      end
      checks++;
      if ({WR_BANK, RD_BANK} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_banks: got wr/rd=%b expected 00", {WR_BANK, RD_BANK});
      end
      checks++;
      if (Sdram_PingPong_EN !== PP) begin
         errors++;
         $display("[TB] FAIL pingpong_en: got %b expected %b", Sdram_PingPong_EN, PP);
      end
      Sdram_Init_Done = 1'b1;
      tick(1);
      checks++;
      if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL skip_entry: got wr/rd/valid=%b expected 110", {WR_LOAD, RD_LOAD, Sdram_Read_Valid});
      end
   endtask

   task automatic test_skip_fill_run();
      for (int f = 0; f < 2; f++) begin
         CAM_VS = 1'b1;
         tick(3);
         CAM_VS = 1'b0;
         checks++;
         if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL skip_frame%0d: got wr/rd/valid=%b expected 110", f, {WR_LOAD, RD_LOAD, Sdram_Read_Valid});
         end
         tick(6);
      end
      CAM_VS = 1'b1;
      tick(3);
      CAM_VS = 1'b0;
      for (int k = 2; k < 6; k++) begin
         checks++;
         if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL fill_pulse N+%0d: got wr/rd/valid=%b expected 110", k, {WR_LOAD, RD_LOAD, Sdram_Read_Valid});
         end
         tick(1);
      end
      checks++;
      if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL fill_pulse_end: got wr/rd/valid=%b expected 010", {WR_LOAD, RD_LOAD, Sdram_Read_Valid});
      end
      tick(3);
      CAM_VS = 1'b1;
      tick(2);
      checks++;
      if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL run_entry N+1: got wr/rd/valid=%b expected 010", {WR_LOAD, RD_LOAD, Sdram_Read_Valid});
      end
      tick(1);
      CAM_VS = 1'b0;
      checks++;
      if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid, FRAME_CNT} !== {3'b101, 8'd0}) begin
         errors++;
         $display("[TB] FAIL run_entry N+2: got wr/rd/valid=%b frame=%0d expected 101 0", {WR_LOAD, RD_LOAD, Sdram_Read_Valid}, FRAME_CNT);
      end
      for (int k = 3; k < 6; k++) begin
         tick(1);
         checks++;
         if (WR_LOAD !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_entry_pulse N+%0d: got %b expected 1", k, WR_LOAD);
         end
      end
      tick(1);
      checks++;
      if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL run_entry_pulse_end: got wr/rd/valid=%b expected 001", {WR_LOAD, RD_LOAD, Sdram_Read_Valid});
      end
      tick(3);
   endtask

   task automatic test_disp_load();
      DISP_VS = 1'b1;
      tick(2);
      checks++;
      if (RD_LOAD !== 1'b0) begin
         errors++;
         $display("[TB] FAIL disp_early N+1: got rd_load=%b expected 0", RD_LOAD);
      end
      tick(1);
      rb_model = ~wb_model;
      exp_wb = PP & wb_model;
      exp_rb = PP & rb_model;
      checks++;
      if ({RD_LOAD, WR_LOAD, WR_BANK, RD_BANK} !== {2'b10, exp_wb, exp_rb}) begin
         errors++;
         $display("[TB] FAIL disp_start N+2: got rd/wr/wb/rb=%b expected %b", {RD_LOAD, WR_LOAD, WR_BANK, RD_BANK}, {2'b10, exp_wb, exp_rb});
      end
      DISP_VS = 1'b0;
      tick(1);
      DISP_VS = 1'b1;
      checks++;
      if (RD_LOAD !== 1'b1) begin
         errors++;
         $display("[TB] FAIL disp_pulse N+3: got %b expected 1", RD_LOAD);
      end
      for (int k = 4; k < 10; k++) begin
         tick(1);
         checks++;
         if (RD_LOAD !== 1'b1) begin
            errors++;
            $display("[TB] FAIL disp_restart N+%0d: got %b expected 1", k, RD_LOAD);
         end
      end
      tick(1);
      checks++;
      if (RD_LOAD !== 1'b0) begin
         errors++;
         $display("[TB] FAIL disp_restart_end N+10: got %b expected 0", RD_LOAD);
      end
      DISP_VS = 1'b0;
      tick(6);
   endtask

   task automatic test_drop();
      for (int f = 1; f <= 3; f++) begin
         CAM_VS = 1'b1;
         tick(3);
         CAM_VS = 1'b0;
         wb_model = ~wb_model;
         exp_wb = PP & wb_model;
         checks++;
         if ({WR_LOAD, WR_BANK, FRAME_CNT, DROP_CNT} !== {1'b1, exp_wb, 8'(f), 8'(f - 1)}) begin
            errors++;
            $display("[TB] FAIL drop_frame%0d: got wr=%b wb=%b frame=%0d drop=%0d expected 1 %b %0d %0d",
                     f, WR_LOAD, WR_BANK, FRAME_CNT, DROP_CNT, exp_wb, f, f - 1);
         end
         checks++;
         if (f2 !== 2'(f)) begin
            errors++;
            $display("[TB] FAIL small_frame%0d: got %0d expected %0d", f, f2, f);
         end
         tick(6);
      end
   endtask

   task automatic test_back_to_back();
      CAM_VS = 1'b1; DISP_VS = 1'b1;
      tick(2);
      checks++;
      if ({WR_LOAD, RD_LOAD} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL both_early N+1: got wr/rd=%b expected 00", {WR_LOAD, RD_LOAD});
      end
      tick(1);
      CAM_VS = 1'b0; DISP_VS = 1'b0;
      rb_model = ~wb_model;
      wb_model = ~wb_model;
      exp_wb = PP & wb_model;
      exp_rb = PP & rb_model;
      checks++;
      if ({WR_LOAD, RD_LOAD, FRAME_CNT, DROP_CNT} !== {2'b11, 8'd4, 8'd2}) begin
         errors++;
         $display("[TB] FAIL both_start: got wr/rd=%b frame=%0d drop=%0d expected 11 4 2", {WR_LOAD, RD_LOAD}, FRAME_CNT, DROP_CNT);
      end
      checks++;
      if ({WR_BANK, RD_BANK} !== {exp_wb, exp_rb}) begin
         errors++;
         $display("[TB] FAIL both_banks: got wb/rb=%b expected %b", {WR_BANK, RD_BANK}, {exp_wb, exp_rb});
      end
      checks++;
      if ({f2, d2} !== 4'b11_10) begin
         errors++;
         $display("[TB] FAIL small_sat: got frame=%0d drop=%0d expected 3 2", f2, d2);
      end
      for (int k = 3; k < 6; k++) begin
         tick(1);
         checks++;
         if ({WR_LOAD, RD_LOAD} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL both_pulse N+%0d: got wr/rd=%b expected 11", k, {WR_LOAD, RD_LOAD});
         end
      end
      tick(1);
      checks++;
      if ({WR_LOAD, RD_LOAD} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL both_pulse_end: got wr/rd=%b expected 00", {WR_LOAD, RD_LOAD});
      end
      tick(3);
      CAM_VS = 1'b1;
      tick(3);
      CAM_VS = 1'b0;
      wb_model = ~wb_model;
      checks++;
      if ({FRAME_CNT, DROP_CNT, f2, d2} !== {8'd5, 8'd3, 2'd3, 2'd3}) begin
         errors++;
         $display("[TB] FAIL after_both: got frame=%0d drop=%0d small=%0d/%0d expected 5 3 3/3", FRAME_CNT, DROP_CNT, f2, d2);
      end
      tick(6);
   endtask

   task automatic test_init_drop();
      Sdram_Init_Done = 1'b0;
      tick(1);
      exp_wb = PP & wb_model;
      exp_rb = PP & rb_model;
      checks++;
      if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid, WR_BANK, RD_BANK} !== {3'b110, exp_wb, exp_rb}) begin
         errors++;
         $display("[TB] FAIL init_drop: got wr/rd/valid/wb/rb=%b expected %b", {WR_LOAD, RD_LOAD, Sdram_Read_Valid, WR_BANK, RD_BANK}, {3'b110, exp_wb, exp_rb});
      end
      CAM_VS = 1'b1;
      tick(4);
      CAM_VS = 1'b0;
      tick(6);
      checks++;
      if ({WR_LOAD, RD_LOAD, Sdram_Read_Valid, FRAME_CNT, DROP_CNT} !== {3'b110, 8'd5, 8'd3}) begin
         errors++;
         $display("[TB] FAIL init_hold_counters: got wr/rd/valid=%b frame=%0d drop=%0d expected 110 5 3",
                  {WR_LOAD, RD_LOAD, Sdram_Read_Valid}, FRAME_CNT, DROP_CNT);
      end
      Sdram_Init_Done = 1'b1;
      tick(1);
      for (int f = 0; f < 4; f++) begin
         CAM_VS = 1'b1;
         tick(3);
         CAM_VS = 1'b0;
         checks++;
         if (Sdram_Read_Valid !== (f == 3)) begin
            errors++;
            $display("[TB] FAIL reinit_frame%0d: got valid=%b expected %b", f, Sdram_Read_Valid, (f == 3));
         end
         tick(6);
      end
      checks++;
      if ({FRAME_CNT, DROP_CNT} !== {8'd5, 8'd3}) begin
         errors++;
         $display("[TB] FAIL reinit_counters: got frame=%0d drop=%0d expected 5 3", FRAME_CNT, DROP_CNT);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_skip_fill_run();
      test_disp_load();
      test_drop();
      test_back_to_back();
      test_init_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
